// File: rtl/fetch_sequencer.sv
// Program-counter owner and instruction-fetch sequencer: issues req/ack fetches to
// instruction memory, holds each instruction for decode and picks the next PC on accept.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic             instr_valid,
  input  logic             instr_ready,
  input  logic             jumpSignal,
  input  logic             branchSignal,
  output logic [31:0]      pc,
  output logic [CNT_W-1:0] retired_count
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } state_t;

  state_t      state;
  logic [31:0] next_pc;
  logic [31:0] branch_off;

  // Jump wins over branch; all arithmetic wraps naturally at 32 bits.
  always_comb begin
    branch_off = {{16{instr[15]}}, instr[15:0]};
    if (jumpSignal)
      next_pc = {pc[31:28], 2'b00, instr[25:0]};
    else if (branchSignal)
      next_pc = pc + 32'd1 + branch_off;
    else
      next_pc = pc + 32'd1;
  end

  assign imem_addr = pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      imem_req      <= 1'b0;
      instr_valid   <= 1'b0;
      instr         <= 32'd0;
      retired_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          // Request for the next PC goes out on the same edge as the accept.
          if (instr_ready) begin
            pc            <= next_pc;
            retired_count <= retired_count + CNT_W'(1);
            instr_valid   <= 1'b0;
            imem_req      <= 1'b1;
            state         <= FETCH;
          end
        end
        default: begin
          state       <= IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: expected fetch addresses and instructions are
// queued as stimulus is driven and compared when the DUT requests / presents them.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_ack, instr_ready, jumpSignal, branchSignal;
  logic [31:0] imem_rdata;

  logic        req0, valid0, req1, valid1, req2, valid2;
  logic [31:0] addr0, instr0, pc0, ret0;
  logic [31:0] addr1, instr1, pc1;
  logic [1:0]  ret1;
  logic [31:0] addr2, instr2, pc2, ret2;

  always #5 clk = ~clk;

  fetch_sequencer #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .imem_req(req0), .imem_addr(addr0), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr0), .instr_valid(valid0), .instr_ready(instr_ready),
    .jumpSignal(jumpSignal), .branchSignal(branchSignal), .pc(pc0), .retired_count(ret0)
  );

  fetch_sequencer #(.RESET_PC(32'hFFFF_FFFF), .CNT_W(2)) dut_w (
    .clk(clk), .reset(reset), .imem_req(req1), .imem_addr(addr1), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr1), .instr_valid(valid1), .instr_ready(instr_ready),
    .jumpSignal(jumpSignal), .branchSignal(branchSignal), .pc(pc1), .retired_count(ret1)
  );

  fetch_sequencer #(.RESET_PC(32'h3000_0004), .CNT_W(32)) dut_j (
    .clk(clk), .reset(reset), .imem_req(req2), .imem_addr(addr2), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr2), .instr_valid(valid2), .instr_ready(instr_ready),
    .jumpSignal(jumpSignal), .branchSignal(branchSignal), .pc(pc2), .retired_count(ret2)
  );

  // Select which instance the checks observe.
  int          sel;
  logic        obs_req, obs_valid;
  logic [31:0] obs_addr, obs_instr, obs_pc, obs_ret;

  always_comb begin
    obs_req   = req0;
    obs_valid = valid0;
    obs_addr  = addr0;
    obs_instr = instr0;
    obs_pc    = pc0;
    obs_ret   = ret0;
    if (sel == 1) begin
      obs_req   = req1;
      obs_valid = valid1;
      obs_addr  = addr1;
      obs_instr = instr1;
      obs_pc    = pc1;
      obs_ret   = {30'd0, ret1};
    end else if (sel == 2) begin
      obs_req   = req2;
      obs_valid = valid2;
      obs_addr  = addr2;
      obs_instr = instr2;
      obs_pc    = pc2;
      obs_ret   = ret2;
    end
  end

  logic [31:0] addr_q[$];
  logic [31:0] instr_q[$];
  logic [31:0] exp_ret, ret_mask, rst_pc;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic pop_addr(output logic [31:0] v);
    check("addr_sb_nonempty", 32'(addr_q.size() != 0), 32'd1);
    v = (addr_q.size() != 0) ? addr_q.pop_front() : 32'hxxxx_xxxx;
  endtask

  task automatic pop_instr(output logic [31:0] v);
    check("instr_sb_nonempty", 32'(instr_q.size() != 0), 32'd1);
    v = (instr_q.size() != 0) ? instr_q.pop_front() : 32'hxxxx_xxxx;
  endtask

  task automatic do_reset(input int s, input logic [31:0] rpc, input logic [31:0] mask);
    sel          = s;
    rst_pc       = rpc;
    ret_mask     = mask;
    reset        = 1'b1;
    imem_ack     = 1'b0;
    instr_ready  = 1'b0;
    jumpSignal   = 1'b0;
    branchSignal = 1'b0;
    imem_rdata   = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_req", 32'(obs_req), 32'd0);
    check("rst_valid", 32'(obs_valid), 32'd0);
    check("rst_instr", obs_instr, 32'd0);
    check("rst_pc", obs_pc, rst_pc);
    check("rst_retired", obs_ret, 32'd0);
    reset = 1'b0;
    addr_q.delete();
    instr_q.delete();
    addr_q.push_back(rst_pc);
    exp_ret = 32'd0;
  endtask

  // Reset asserted between edges: outputs must drop before any clock edge.
  task automatic mid_reset();
    #2 reset = 1'b1;
    #1;
    check("mid_rst_req", 32'(obs_req), 32'd0);
    check("mid_rst_valid", 32'(obs_valid), 32'd0);
    check("mid_rst_pc", obs_pc, rst_pc);
    check("mid_rst_instr", obs_instr, 32'd0);
    check("mid_rst_retired", obs_ret, 32'd0);
    @(negedge clk);
    imem_ack = 1'b0;
    reset    = 1'b0;
    addr_q.delete();
    instr_q.delete();
    addr_q.push_back(rst_pc);
    exp_ret = 32'd0;
  endtask

  task automatic wait_req();
    int waited = 0;
    while (!obs_req && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("req_seen", 32'(obs_req), 32'd1);
  endtask

  task automatic fetch_one(input logic [31:0] data, input int ack_dly, input int rdy_dly,
                           input logic j, input logic b, input logic [31:0] nxt,
                           input bit abort);
    logic [31:0] ea, ei;
    wait_req();
    if (!obs_req) return;
    pop_addr(ea);
    check("addr", obs_addr, ea);
    // Memory stall; decode-side inputs wiggle and must be ignored in FETCH.
    repeat (ack_dly) begin
      imem_ack    = 1'b0;
      instr_ready = 1'b1;
      jumpSignal  = 1'b1;
      @(negedge clk);
      check("req_stall", 32'(obs_req), 32'd1);
      check("addr_stall", obs_addr, ea);
      check("valid_stall", 32'(obs_valid), 32'd0);
    end
    instr_ready = 1'b0;
    jumpSignal  = 1'b0;
    imem_ack    = 1'b1;
    imem_rdata  = data;
    instr_q.push_back(data);
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    check("valid", 32'(obs_valid), 32'd1);
    check("req_off", 32'(obs_req), 32'd0);
    pop_instr(ei);
    check("instr", obs_instr, ei);
    check("pc_hold", obs_pc, ea);
    repeat (rdy_dly) begin
      instr_ready = 1'b0;
      @(negedge clk);
      check("valid_hold", 32'(obs_valid), 32'd1);
      check("instr_hold", obs_instr, data);
      check("pc_stall", obs_pc, ea);
      check("retired_stall", obs_ret, exp_ret);
    end
    if (abort) begin
      mid_reset();
      $display("txn sel=%0d addr=%h instr=%h aborted by reset", sel, ea, data);
      return;
    end
    instr_ready  = 1'b1;
    jumpSignal   = j;
    branchSignal = b;
    addr_q.push_back(nxt);
    exp_ret = (exp_ret + 32'd1) & ret_mask;
    @(negedge clk);
    instr_ready  = 1'b0;
    jumpSignal   = 1'b0;
    branchSignal = 1'b0;
    check("refetch", 32'(obs_req), 32'd1);
    check("retired", obs_ret, exp_ret);
    $display("txn sel=%0d addr=%h instr=%h next=%h retired=%0d", sel, ea, data, nxt, obs_ret);
  endtask

  initial begin
    logic [31:0] ea;
    sel = 0;
    do_reset(0, 32'h0000_0000, 32'hFFFF_FFFF);

    // Sequential, zero-wait memory, decode always ready.
    for (int i = 0; i < 4; i++)
      fetch_one($urandom, 0, 0, 1'b0, 1'b0, 32'(i + 1), 1'b0);
    check("retired4", obs_ret, 32'd4);

    // Reach pc 0x10, then branches with negative and positive offsets.
    fetch_one(32'h0000_0010, 0, 0, 1'b1, 1'b0, 32'h0000_0010, 1'b0);
    fetch_one(32'h1234_FFFC, 0, 0, 1'b0, 1'b1, 32'h0000_000D, 1'b0);
    fetch_one(32'h0800_0010, 0, 0, 1'b1, 1'b0, 32'h0000_0010, 1'b0);
    fetch_one(32'h0000_0005, 0, 0, 1'b0, 1'b1, 32'h0000_0016, 1'b0);

    // Memory stall of 3 cycles and decode stall of 5 cycles.
    fetch_one(32'hCAFE_0001, 3, 5, 1'b0, 1'b0, 32'h0000_0017, 1'b0);

    // Reset while held in HOLD.
    fetch_one(32'hBEEF_0002, 0, 2, 1'b0, 1'b0, 32'h0000_0018, 1'b1);

    // Reset in FETCH with an ack pending: the ack must be ignored.
    wait_req();
    pop_addr(ea);
    check("addr_pre_rst", obs_addr, ea);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    mid_reset();
    fetch_one(32'h1111_2222, 0, 0, 1'b0, 1'b0, 32'h0000_0001, 1'b0);

    // Jump has priority over branch; upper pc nibble preserved.
    do_reset(2, 32'h3000_0004, 32'hFFFF_FFFF);
    fetch_one(32'hFC00_0123, 0, 0, 1'b1, 1'b1, 32'h3000_0123, 1'b0);
    fetch_one(32'h0000_0000, 0, 0, 1'b0, 1'b0, 32'h3000_0124, 1'b0);

    // PC wrap from all-ones, and a 2-bit retired counter wrapping to 0.
    do_reset(1, 32'hFFFF_FFFF, 32'h0000_0003);
    for (int i = 0; i < 4; i++)
      fetch_one($urandom, 0, 0, 1'b0, 1'b0, 32'(i), 1'b0);
    check("retired_wrap", obs_ret, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
